// File: rtl/gate_op_scheduler_pkg.sv
// Shared constants for the gate-op scheduler: op codes and FSM state encodings.
package gate_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

endpackage

// File: rtl/gate_op_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    // Scan ptr, ptr+1, ... and take the first valid requester.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/gate_op_scheduler.sv
// Shares one registered AND/OR/XOR/NAND unit among NREQ requesters.
// Capture (IDLE) -> evaluate (EVAL) -> hold result until consumed (RESP).
module gate_op_scheduler
    import gate_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ*2-1:0]       req_op,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [WIDTH-1:0]        resp_data,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        op_count
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0][WIDTH-1:0] a_vec, b_vec;
    logic [NREQ-1:0][1:0]       op_vec;

    assign a_vec  = req_a;
    assign b_vec  = req_b;
    assign op_vec = req_op;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [IW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IW-1:0]     rid_q, rid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Gate datapath result for the captured operands.
    logic [WIDTH-1:0] gate_res;
    always_comb begin
        gate_res = '0;
        case (op_q)
            OP_AND:  gate_res = a_q & b_q;
            OP_OR:   gate_res = a_q | b_q;
            OP_XOR:  gate_res = a_q ^ b_q;
            default: gate_res = ~(a_q & b_q);
        endcase
    end

    // Next-state: capture on grant, evaluate once, then wait for the consumer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        data_d  = data_q;
        rid_d   = rid_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    a_d     = a_vec[arb_idx];
                    b_d     = b_vec[arb_idx];
                    op_d    = op_vec[arb_idx];
                    id_d    = arb_idx;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                data_d  = gate_res;
                rid_d   = id_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    // Pointer moves past the served requester only on completion.
                    ptr_d   = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= '0;
            data_q  <= '0;
            rid_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            data_q  <= data_d;
            rid_q   <= rid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE) ? arb_grant : '0;
    assign resp_valid = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign resp_data  = data_q;
    assign resp_id    = rid_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Randomized + directed bench for gate_op_scheduler with a transaction-level model.
module tb_gate_op_scheduler;
    import gate_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        valid;
    logic [NREQ-1:0][7:0]   va, vb;
    logic [NREQ-1:0][1:0]   vop;
    logic                   resp_ready;
    logic [NREQ-1:0]        req_ready;
    logic                   resp_valid;
    logic [WIDTH-1:0]       resp_data;
    logic [1:0]             resp_id;
    logic                   busy;
    logic [CNT_W-1:0]       op_count;

    gate_op_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (valid),
        .req_ready  (req_ready),
        .req_a      (va),
        .req_b      (vb),
        .req_op     (vop),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_valid(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] gate_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Transaction model: one outstanding op, age counts edges since accept.
    int         m_ptr = 0;
    int         m_cnt = 0;
    bit         m_has = 0;
    int         m_age = 0;
    int         m_id  = 0;
    logic [7:0] m_data = '0;
    int         last_grant = -1;
    int         gq[$];
    logic [7:0] dq[$];

    always @(posedge clk) begin
        int g;
        // Observed DUT transfers, used only for literal sequence checks.
        if (resp_valid && resp_ready && !rst) dq.push_back(resp_data);
        for (int i = 0; i < NREQ; i++) if (req_ready[i] && !rst) gq.push_back(i);
        last_grant = -1;
        if (rst) begin
            m_has = 0; m_ptr = 0; m_cnt = 0; m_age = 0;
        end else if (!m_has) begin
            g = first_valid(valid, m_ptr);
            if (g >= 0) begin
                m_has = 1; m_age = 1; m_id = g;
                m_data = gate_ref(va[g], vb[g], vop[g]);
                last_grant = g;
            end
        end else if (m_age < 2) begin
            m_age++;
        end else if (resp_ready) begin
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            m_ptr = (m_id + 1) % NREQ;
            m_has = 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int g;
        exp_rdy = '0;
        if (!m_has) begin
            g = first_valid(valid, m_ptr);
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("resp_valid", 32'(resp_valid), 32'(m_has && m_age == 2));
        chk("busy", 32'(busy), 32'(m_has));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        if (m_has && m_age == 2) begin
            chk("resp_data", 32'(resp_data), 32'(m_data));
            chk("resp_id", 32'(resp_id), 32'(m_id));
        end
    end

    bit auto_clr = 1;

    task automatic tick();
        @(negedge clk);
        #1;
        if (auto_clr && last_grant >= 0) valid[last_grant] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = '0;
        tick();
        rst = 1'b0;
        gq.delete(); dq.delete();
    endtask

    task automatic wait_dq(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (dq.size() < n && c < budget) begin tick(); c++; end
        if (dq.size() < n) chk({name, "_timeout"}, 32'(dq.size()), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz, c, seen;
        rst = 1'b1; valid = '0; va = '0; vb = '0; vop = '0; resp_ready = 1'b0;
        tick();
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", 32'(resp_data), 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Single request, AND, checked 2 edges after accept.
        valid = 4'b0001; va[0] = 8'hF0; vb[0] = 8'h3C; vop[0] = OP_AND;
        #1 chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_eval_valid", 32'(resp_valid), 32'h0);
        tick();
        chk("t1_valid", 32'(resp_valid), 32'h1);
        chk("t1_data", 32'(resp_data), 32'h30);
        chk("t1_id", 32'(resp_id), 32'h0);

        // Back-pressure holds the response; new request waits.
        valid = 4'b0010;
        repeat (5) begin
            tick();
            chk("t3_valid", 32'(resp_valid), 32'h1);
            chk("t3_data", 32'(resp_data), 32'h30);
            chk("t3_id", 32'(resp_id), 32'h0);
            chk("t3_ready", 32'(req_ready), 32'h0);
            chk("t3_busy", 32'(busy), 32'h1);
        end
        resp_ready = 1'b1; valid = '0;
        tick();
        chk("t3_count", 32'(op_count), 32'h1);
        chk("t3_after_valid", 32'(resp_valid), 32'h0);

        // Four simultaneous requests, all four ops.
        do_reset();
        valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin va[i] = 8'hAA; vb[i] = 8'h0F; vop[i] = 2'(i); end
        wait_dq(4, 40, "t2");
        if (gq.size() >= 4 && dq.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("t2_grant", 32'(gq[i]), 32'(i));
            chk("t2_d0", 32'(dq[0]), 32'h0A);
            chk("t2_d1", 32'(dq[1]), 32'hAF);
            chk("t2_d2", 32'(dq[2]), 32'hA5);
            chk("t2_d3", 32'(dq[3]), 32'hF5);
        end

        // Fairness between requesters 1 and 3 starting from ptr=2.
        do_reset();
        valid = 4'b0010; va[1] = 8'h55; vb[1] = 8'h33; vop[1] = OP_XOR;
        wait_dq(1, 20, "t4a");
        auto_clr = 0;
        valid = 4'b1010; va[3] = 8'h0F; vb[3] = 8'hF0; vop[3] = OP_OR;
        c = 0;
        while (gq.size() < 5 && c < 40) begin tick(); c++; end
        chk("t4_grants", 32'(gq.size() >= 5), 32'h1);
        if (gq.size() >= 5) begin
            chk("t4_g0", 32'(gq[0]), 32'h1);
            chk("t4_g1", 32'(gq[1]), 32'h3);
            chk("t4_g2", 32'(gq[2]), 32'h1);
            chk("t4_g3", 32'(gq[3]), 32'h3);
            chk("t4_g4", 32'(gq[4]), 32'h1);
        end
        valid = '0; auto_clr = 1;
        c = 0;
        while (busy && c < 20) begin tick(); c++; end
        chk("t4_idle", 32'(busy), 32'h0);

        // Reset while in EVAL drops the op.
        chk("t5_nonzero_count", 32'(op_count != 0), 32'h1);
        valid = 4'b0001; va[0] = 8'h12; vb[0] = 8'h34; vop[0] = OP_AND;
        tick();
        chk("t5_in_eval", 32'(busy && !resp_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_valid", 32'(resp_valid), 32'h0);
        chk("t5_count", 32'(op_count), 32'h0);
        sz = dq.size();
        seen = 0;
        repeat (4) begin tick(); if (resp_valid) seen++; end
        chk("t5_no_resp", 32'(seen), 32'h0);
        chk("t5_dq", 32'(dq.size()), 32'(sz));

        // Counter wrap with CNT_W=4.
        do_reset();
        resp_ready = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            sz = dq.size();
            valid = 4'b0100; va[2] = 8'(n); vb[2] = 8'hFF; vop[2] = OP_NAND;
            c = 0;
            while (dq.size() == sz && c < 10) begin tick(); c++; end
            if (dq.size() == sz) chk("t6_timeout", 32'(dq.size()), 32'(sz + 1));
            if (n == 15) chk("t6_c15", 32'(op_count), 32'hF);
            if (n == 16) chk("t6_wrap", 32'(op_count), 32'h0);
        end

        // Randomized traffic with back-pressure and occasional reset.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid[i] && $urandom_range(0, 3) == 0) begin
                    valid[i] = 1'b1;
                    va[i] = 8'($urandom); vb[i] = 8'($urandom); vop[i] = 2'($urandom);
                end else if (valid[i] && $urandom_range(0, 31) == 0) begin
                    valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
